// File: rtl/board_reset_clock_ctrl_pkg.sv
// Shared board clock/reset types and sizing helpers.
package board_reset_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    PRESS = 2'd2
  } rst_state_t;

  // A counter that never exceeds limit-1 needs at least one bit, even for tiny limits.
  function automatic int cnt_width(input int limit);
    return (limit > 2) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/board_reset_clock_ctrl_button_debouncer.sv
// Push-button synchroniser followed by a stable-level debounce counter.
module button_debouncer
  import board_reset_clock_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic btn_db_o
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DB_W-1:0]        db_cnt;
  logic                   btn_s;

  assign btn_s = sync[SYNC_STAGES-1];

  // NOTE: every register in this file is written with <= so all flops update from
  // pre-edge values; a blocking = here would collapse the synchroniser into one stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      db_cnt   <= '0;
      btn_db_o <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn_i};
      if (btn_s == btn_db_o) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db_o <= btn_s;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/board_reset_clock_ctrl.sv
// Board clock divider, debounced reset button and stretched active-low SoC reset.
module board_reset_clock_ctrl
  import board_reset_clock_ctrl_pkg::*;
#(
  parameter int CLK_DIV           = 2,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_i,
  output logic       clk_div_o,
  output logic       clk_en_o,
  output logic       soc_rst_n_o,
  output logic       btn_db_o,
  output logic [1:0] state_o
);

  localparam int                DIV_W     = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_MID   = DIV_W'(CLK_DIV / 2 - 1);
  localparam int                HOLD_W    = cnt_width(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic [DIV_W-1:0]  div_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  rst_state_t        state;
  rst_state_t        next_state;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_i),
    .btn_db_o(btn_db_o)
  );

  // clk_div_o rises together with the clk_en_o pulse and falls half a period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      clk_div_o <= 1'b0;
      clk_en_o  <= 1'b0;
    end else begin
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      clk_en_o <= (div_cnt == DIV_LAST);
      if (div_cnt == DIV_LAST) begin
        clk_div_o <= 1'b1;
      end else if (div_cnt == DIV_MID) begin
        clk_div_o <= 1'b0;
      end
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      HOLD: begin
        if (btn_db_o) begin
          next_state = PRESS;
        end else if (clk_en_o && hold_cnt == HOLD_LAST) begin
          next_state = RUN;
        end
      end
      RUN:     if (btn_db_o)  next_state = PRESS;
      PRESS:   if (!btn_db_o) next_state = HOLD;
      default: next_state = HOLD;
    endcase
  end

  // soc_rst_n_o follows next_state so the reset edge lines up with the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      soc_rst_n_o <= 1'b0;
    end else begin
      state       <= next_state;
      soc_rst_n_o <= (next_state == RUN);
      if (state == HOLD && next_state == HOLD) begin
        if (clk_en_o) hold_cnt <= hold_cnt + HOLD_W'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_board_reset_clock_ctrl.sv
// Scoreboard bench: two instances (CLK_DIV=2 and CLK_DIV=4) with directed button stimulus.
module tb_board_reset_clock_ctrl;

  typedef enum int {F_DIV, F_EN, F_RSTN, F_DB, F_ST,
                    F_DIV4, F_EN4, F_RSTN4, F_DB4, F_ST4} field_e;

  typedef struct {
    int          cyc;
    field_e      f;
    logic [1:0]  v;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn, btn4;
  logic       div, en, rst_n, db;
  logic [1:0] st;
  logic       div4, en4, rst_n4, db4;
  logic [1:0] st4;

  int   cyc = 0;
  int   r0  = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  board_reset_clock_ctrl #(
    .CLK_DIV(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn),
    .clk_div_o(div), .clk_en_o(en), .soc_rst_n_o(rst_n), .btn_db_o(db), .state_o(st)
  );

  board_reset_clock_ctrl #(
    .CLK_DIV(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_HOLD_CYCLES(4)
  ) dut4 (
    .clk(clk), .rst(rst), .btn_i(btn4),
    .clk_div_o(div4), .clk_en_o(en4), .soc_rst_n_o(rst_n4), .btn_db_o(db4), .state_o(st4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] actual(input field_e f);
    case (f)
      F_DIV:   return {1'b0, div};
      F_EN:    return {1'b0, en};
      F_RSTN:  return {1'b0, rst_n};
      F_DB:    return {1'b0, db};
      F_ST:    return st;
      F_DIV4:  return {1'b0, div4};
      F_EN4:   return {1'b0, en4};
      F_RSTN4: return {1'b0, rst_n4};
      F_DB4:   return {1'b0, db4};
      default: return st4;
    endcase
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input field_e f, input logic [1:0] v, input string name);
    exp_t e;
    int   i;
    e.cyc = c; e.f = f; e.v = v; e.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: outputs are registered, so every negedge presents a stable sample.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
        end else begin
          check(e.name, actual(e.f), e.v);
        end
      end
    end
  end

  // Reset for 3 clk, then release and expect the power-up sequence on both instances.
  task automatic run_seq1(input string tag);
    int c;
    c   = cyc;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      expect_at(c+k, F_DIV,   2'd0, {tag, "_rst_div"});
      expect_at(c+k, F_EN,    2'd0, {tag, "_rst_en"});
      expect_at(c+k, F_RSTN,  2'd0, {tag, "_rst_rstn"});
      expect_at(c+k, F_DB,    2'd0, {tag, "_rst_db"});
      expect_at(c+k, F_ST,    2'd0, {tag, "_rst_state"});
      expect_at(c+k, F_DIV4,  2'd0, {tag, "_rst_div4"});
      expect_at(c+k, F_EN4,   2'd0, {tag, "_rst_en4"});
      expect_at(c+k, F_RSTN4, 2'd0, {tag, "_rst_rstn4"});
      expect_at(c+k, F_ST4,   2'd0, {tag, "_rst_state4"});
    end
    wait_cyc(c+3);
    rst = 1'b0;
    r0  = cyc;
    for (int n = 1; n <= 20; n++) begin
      if (n <= 12) begin
        expect_at(r0+n, F_DIV,  (n % 2 == 0) ? 2'd1 : 2'd0, $sformatf("%s_div_n%0d", tag, n));
        expect_at(r0+n, F_EN,   (n % 2 == 0) ? 2'd1 : 2'd0, $sformatf("%s_en_n%0d", tag, n));
        expect_at(r0+n, F_RSTN, (n >= 9) ? 2'd1 : 2'd0, $sformatf("%s_rstn_n%0d", tag, n));
        expect_at(r0+n, F_ST,   (n >= 9) ? 2'd1 : 2'd0, $sformatf("%s_state_n%0d", tag, n));
        expect_at(r0+n, F_DB,   2'd0, $sformatf("%s_db_n%0d", tag, n));
      end
      expect_at(r0+n, F_DIV4, (n >= 4 && (n % 4 == 0 || n % 4 == 1)) ? 2'd1 : 2'd0,
                $sformatf("%s_div4_n%0d", tag, n));
      expect_at(r0+n, F_EN4,  (n >= 4 && n % 4 == 0) ? 2'd1 : 2'd0,
                $sformatf("%s_en4_n%0d", tag, n));
      expect_at(r0+n, F_RSTN4, (n >= 17) ? 2'd1 : 2'd0, $sformatf("%s_rstn4_n%0d", tag, n));
      expect_at(r0+n, F_ST4,   (n >= 17) ? 2'd1 : 2'd0, $sformatf("%s_state4_n%0d", tag, n));
    end
    wait_cyc(r0+20);
  endtask

  initial begin
    int s;
    rst  = 1'b1;
    btn  = 1'b0;
    btn4 = 1'b0;
    @(negedge clk);

    // Power-up sequence, both divider ratios.
    run_seq1("t1");

    // Bouncing button in RUN never reaches btn_db_o.
    s = cyc;
    for (int k = 1; k <= 42; k++) begin
      expect_at(s+k, F_DB,   2'd0, $sformatf("t2_db_k%0d", k));
      expect_at(s+k, F_RSTN, 2'd1, $sformatf("t2_rstn_k%0d", k));
      expect_at(s+k, F_ST,   2'd1, $sformatf("t2_state_k%0d", k));
    end
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn = ~btn;
      wait_cyc(s+i+1);
    end
    btn = 1'b0;
    wait_cyc(s+42);

    // Clean 20-clk press in RUN, aligned so clk_en_o pulses follow even offsets.
    if ((cyc - r0) % 2 != 0) wait_cyc(cyc+1);
    s = cyc;
    expect_at(s+9,  F_DB,   2'd0, "t3_db_before_rise");
    expect_at(s+10, F_DB,   2'd1, "t3_db_rise");
    expect_at(s+10, F_RSTN, 2'd1, "t3_rstn_still_high");
    expect_at(s+10, F_ST,   2'd1, "t3_state_run");
    expect_at(s+11, F_RSTN, 2'd0, "t3_rstn_fall");
    expect_at(s+11, F_ST,   2'd2, "t3_state_press");
    expect_at(s+29, F_DB,   2'd1, "t3_db_before_fall");
    expect_at(s+30, F_DB,   2'd0, "t3_db_fall");
    expect_at(s+30, F_ST,   2'd2, "t3_state_press_end");
    expect_at(s+31, F_ST,   2'd0, "t3_state_hold");
    expect_at(s+31, F_RSTN, 2'd0, "t3_rstn_hold");
    expect_at(s+38, F_RSTN, 2'd0, "t3_rstn_before_release");
    expect_at(s+38, F_ST,   2'd0, "t3_state_before_release");
    expect_at(s+39, F_RSTN, 2'd1, "t3_rstn_release");
    expect_at(s+39, F_ST,   2'd1, "t3_state_run_again");
    btn = 1'b1;
    wait_cyc(s+20);
    btn = 1'b0;
    wait_cyc(s+40);

    // CLK_DIV=4 instance: button re-pressed while in HOLD, hold count must restart.
    while ((cyc - r0) % 4 != 0) wait_cyc(cyc+1);
    s = cyc;
    expect_at(s+9,  F_DB4,   2'd0, "t4_db4_before_rise");
    expect_at(s+10, F_DB4,   2'd1, "t4_db4_rise");
    expect_at(s+10, F_ST4,   2'd1, "t4_state4_run");
    expect_at(s+11, F_ST4,   2'd2, "t4_state4_press");
    expect_at(s+11, F_RSTN4, 2'd0, "t4_rstn4_fall");
    expect_at(s+22, F_DB4,   2'd0, "t4_db4_fall");
    expect_at(s+22, F_ST4,   2'd2, "t4_state4_press_end");
    expect_at(s+23, F_ST4,   2'd0, "t4_state4_hold");
    expect_at(s+31, F_DB4,   2'd0, "t4_db4_before_repress");
    expect_at(s+31, F_ST4,   2'd0, "t4_state4_hold_mid");
    expect_at(s+32, F_DB4,   2'd1, "t4_db4_repress");
    expect_at(s+32, F_ST4,   2'd0, "t4_state4_hold_last");
    expect_at(s+33, F_ST4,   2'd2, "t4_state4_press_again");
    expect_at(s+50, F_DB4,   2'd0, "t4_db4_release");
    expect_at(s+51, F_ST4,   2'd0, "t4_state4_hold_again");
    expect_at(s+64, F_RSTN4, 2'd0, "t4_rstn4_full_hold");
    expect_at(s+64, F_ST4,   2'd0, "t4_state4_full_hold");
    expect_at(s+65, F_RSTN4, 2'd1, "t4_rstn4_release");
    expect_at(s+65, F_ST4,   2'd1, "t4_state4_run_again");
    btn4 = 1'b1;
    wait_cyc(s+12);
    btn4 = 1'b0;
    wait_cyc(s+22);
    btn4 = 1'b1;
    wait_cyc(s+40);
    btn4 = 1'b0;
    wait_cyc(s+70);

    // rst asserted while clk_div_o is high in RUN; power-up sequence repeats exactly.
    if ((cyc + 1 - r0) % 2 != 0) wait_cyc(cyc+1);
    s = cyc;
    expect_at(s+1, F_DIV,  2'd1, "t5_div_high_before_rst");
    expect_at(s+1, F_RSTN, 2'd1, "t5_rstn_before_rst");
    expect_at(s+1, F_ST,   2'd1, "t5_state_before_rst");
    wait_cyc(s+1);
    run_seq1("t5");

    wait_cyc(cyc+3);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      errors++;
      $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
